uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Oversampling asynchronous serial receiver, 8N1 by default. It is the receive-side counterpart of the UART transmitter already driven by the shared baud divider.
- Samples a raw, unsynchronised rx line and validates the start bit at mid-bit. Shifts in data LSB-first, checks the stop bit, and presents each byte in a one-deep holding register.
- Reports overrun and framing errors.
- Sits between the serial console pin and the DL11-style register interface.

Parameters:
- INCLK, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 4.
- DATABITS, 8, data bits per character; legal range 5..8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- async_reset  in  1  reset, asynchronous, active-high.
- rx  in  1  raw serial input; idle = 1.
- rd  in  1  one-cycle acknowledge from the consumer; clears valid and the error flags.
- data  out  8  received character, right-justified; unused upper bits are 0.
- valid  out  1  data holds an unread character.
- overrun  out  1  sticky: a character completed while valid=1.
- framing_err  out  1  sticky: a stop bit was sampled as 0.
- busy  out  1  receiver is not IDLE.

Behaviour:
- Reset:
  - async_reset clears every flop immediately, regardless of clk.
  - data=0, valid=0, overrun=0, framing_err=0, busy=0.
  - State = IDLE, tick counter = 0, sample counter = 0.
  - The rx synchroniser flops are preset to 1.
  - Reset mid-character abandons the character; no flags are set.
- Synchroniser: rx passes through 2 flops to give rx_s; all decisions use rx_s only.
- Tick generator:
  - Free-running 16-bit counter produces a one-clk tick every DIV = INCLK/(BAUD*OVERSAMPLE) clocks (integer division).
  - At the defaults DIV = 325, and one bit = 5200 clk.
  - Counter wraps to 0 on tick; it is not restarted by start detection.
- State machine (sample counter scnt, bit counter bcnt). All transitions occur on tick cycles only.
  - IDLE: when rx_s==0 on a tick, go to START with scnt=1.
  - START: scnt increments each tick. When scnt==OVERSAMPLE/2, sample rx_s:
    - rx_s==1: glitch, return to IDLE with no flags.
    - rx_s==0: set scnt=0, bcnt=0, go to DATA.
  - DATA: scnt increments each tick. When scnt==OVERSAMPLE-1, shift rx_s into the MSB of the DATABITS-wide shift register (LSB-first line order), set scnt=0, bcnt++. After DATABITS bits, go to STOP.
  - STOP: at scnt==OVERSAMPLE-1, sample rx_s:
    - 1: deliver the character, go to IDLE.
    - 0: set framing_err, discard the character, go to BREAK.
  - BREAK: stay until rx_s==1 on a tick, then go to IDLE. A held-low line therefore produces exactly one framing_err.
- busy = (state != IDLE).
- Delivery, same clk as the stop-sample tick, with results visible the next clk:
  - If valid==0, or rd==1 in that same clk: data is loaded and valid=1.
  - If valid==1 and rd==0: data keeps the old character, the new one is dropped, and overrun=1.
- rd:
  - When asserted, valid, overrun and framing_err clear on the next clk.
  - rd while valid==0 is harmless.
  - If a set event for a flag coincides with rd, the set wins.
- Latency: from the rx falling edge to valid rising is about (DATABITS+1.5) bit times, plus up to 1 tick of detection jitter, plus 2 clk of synchroniser delay. At the defaults this is 49400..49727 clk.
- Sampling is a single sample at mid-bit; there is no majority vote.

Test Plan:
- Default parameters, send 0x55 8N1 at 5200 clk/bit -> valid rises in 49400..49727 clk after the start edge, data=0x55, overrun=0, framing_err=0, busy returns to 0.
- Send 0xA3 and leave it unread, then send 0x3C -> data stays 0xA3 and overrun=1. Pulse rd -> valid=0, overrun=0 next clk.
- Send 0x00 with the stop bit forced 0, then hold rx=0 for 20 bit times -> framing_err=1 exactly once, valid=0, busy stays 1 until rx returns to 1. Then send 0x81 -> data=0x81, valid=1.
- Drive rx low for 2000 clk (shorter than half a bit) -> state returns to IDLE, valid and framing_err stay 0.
- Assert async_reset for 3 clk midway through bit 4 of 0xFF -> all outputs 0 immediately, busy=0. A following 0x12 is received correctly.
- Use DATABITS=7, send 0x7F, and pulse rd in the same clk as the next character's stop sample -> data=0x7F with data[7]=0, then the new byte replaces it with valid held at 1 and no overrun.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1-style serial receiver
// with a one-deep holding register and sticky errors.
module uart_rx_os #(
   parameter int INCLK      = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATABITS   = 8
) (
   input  logic       clk,
   input  logic       async_reset,
   input  logic       rx,
   input  logic       rd,
   output logic [7:0] data,
   output logic       valid,
   output logic       overrun,
   output logic       framing_err,
   output logic       busy
);

   localparam int DIV = INCLK / (BAUD * OVERSAMPLE);
   localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] HALF_C = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] LAST_C = SW'(OVERSAMPLE - 1);
   localparam logic [3:0] BLAST_C = 4'(DATABITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   logic                rx_meta_q, rx_s_q;
   logic [15:0]         tcnt_q, tcnt_d;
   logic                tick;
   state_t              state_q, state_d;
   logic [SW-1:0]       scnt_q, scnt_d;
   logic [3:0]          bcnt_q, bcnt_d;
   logic [DATABITS-1:0] shreg_q, shreg_d;
   logic [7:0]          data_q, data_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;
   logic                ferr_q, ferr_d;
   logic                deliver, frame_bad;

   // two-flop synchroniser, idles high so reset looks like a quiet line
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // free-running sample tick; never resynchronised to the start edge
   always_comb begin
      tick   = (tcnt_q == DIV_M1);
      tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;
   end

   // receive sequencer: all decisions are taken on tick cycles
   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      bcnt_d    = bcnt_q;
      shreg_d   = shreg_q;
      deliver   = 1'b0;
      frame_bad = 1'b0;
      if (tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d = S_START;
                  scnt_d  = SW'(1);
               end
            end
            S_START: begin
               if (scnt_q == HALF_C) begin
                  scnt_d = '0;
                  if (rx_s_q) begin
                     state_d = S_IDLE;
                  end else begin
                     bcnt_d  = '0;
                     state_d = S_DATA;
                  end
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (scnt_q == LAST_C) begin
                  shreg_d = {rx_s_q, shreg_q[DATABITS-1:1]};
                  scnt_d  = '0;
                  bcnt_d  = bcnt_q + 4'd1;
                  if (bcnt_q == BLAST_C) begin
                     state_d = S_STOP;
                  end
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (scnt_q == LAST_C) begin
                  scnt_d = '0;
                  if (rx_s_q) begin
                     deliver = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     frame_bad = 1'b1;
                     state_d   = S_BRK;
                  end
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            S_BRK: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               scnt_d  = '0;
            end
         endcase
      end
   end

   // holding register and sticky flags; a set beats a same-cycle rd
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q & ~rd;
      overrun_d = overrun_q & ~rd;
      ferr_d    = ferr_q & ~rd;
      if (deliver) begin
         if (!valid_q || rd) begin
            data_d  = 8'(shreg_q);
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (frame_bad) begin
         ferr_d = 1'b1;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         tcnt_q    <= '0;
         state_q   <= S_IDLE;
         scnt_q    <= '0;
         bcnt_q    <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         tcnt_q    <= tcnt_d;
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         bcnt_q    <= bcnt_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign overrun     = overrun_q;
   assign framing_err = ferr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: random and directed frames checked
// against a character-level model of the receiver.
module tb_uart_rx_os;

   localparam int INCLK = 614400;
   localparam int BAUD  = 9600;
   localparam int OVS   = 16;
   localparam int DIV   = 4;
   localparam int BIT   = OVS * DIV;
   localparam int BIG   = 32'h7fffffff;

   logic       clk = 1'b0;
   logic       async_reset, rx, rd, rx7, rd7;
   logic [7:0] data, data7;
   logic       valid, overrun, framing_err, busy;
   logic       valid7, overrun7, framing_err7, busy7;

   uart_rx_os #(
      .INCLK(INCLK), .BAUD(BAUD), .OVERSAMPLE(OVS), .DATABITS(8)
   ) dut (
      .clk(clk), .async_reset(async_reset), .rx(rx), .rd(rd),
      .data(data), .valid(valid), .overrun(overrun),
      .framing_err(framing_err), .busy(busy)
   );

   uart_rx_os #(
      .INCLK(INCLK), .BAUD(BAUD), .OVERSAMPLE(OVS), .DATABITS(7)
   ) dut7 (
      .clk(clk), .async_reset(async_reset), .rx(rx7), .rd(rd7),
      .data(data7), .valid(valid7), .overrun(overrun7),
      .framing_err(framing_err7), .busy(busy7)
   );

   always #5 clk = ~clk;

   int cyc = 0, rel = 0, n_chk = 0, n_err = 0;
   logic [7:0] m_data;
   logic m_valid, m_ovr, m_fe;
   int pend_s = -1;
   logic [7:0] pend_b;
   logic pend_ok;
   int busy_lo = 0, busy_hi = 0;
   int rise_cyc = -1, fe_rises = 0;
   logic prev_v = 1'b0, prev_fe = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_fe    = 1'b0;
      pend_s  = -1;
      busy_lo = 0;
      busy_hi = 0;
   endtask

   // first tick edge at or after posedge c: ticks fall every DIV
   // posedges counted from reset release
   function automatic int next_tick(input int c);
      int p = c;
      while (p <= rel || ((p - rel) % DIV) != 0) p++;
      return p;
   endfunction

   // character-level model, advanced once per posedge
   initial begin : model_p
      logic r, nv, no, nf;
      logic [7:0] nd;
      forever begin
         @(posedge clk);
         cyc++;
         if (!async_reset) begin
            r  = rd;
            nv = m_valid & ~r;
            no = m_ovr & ~r;
            nf = m_fe & ~r;
            nd = m_data;
            if (cyc == pend_s) begin
               if (pend_ok) begin
                  if (!m_valid || r) begin
                     nd = pend_b;
                     nv = 1'b1;
                  end else begin
                     no = 1'b1;
                  end
               end else begin
                  nf = 1'b1;
               end
               pend_s = -1;
            end
            m_data  = nd;
            m_valid = nv;
            m_ovr   = no;
            m_fe    = nf;
         end
      end
   end

   // compare process: every negedge against the model
   initial begin
      forever begin
         @(negedge clk);
         check("data", data, m_data);
         check("valid", valid, m_valid);
         check("overrun", overrun, m_ovr);
         check("framing_err", framing_err, m_fe);
         check("busy", busy, (cyc >= busy_lo && cyc < busy_hi));
         if (valid && !prev_v) rise_cyc = cyc;
         if (framing_err && !prev_fe) fe_rises++;
         prev_v  = valid;
         prev_fe = framing_err;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input logic v);
      if (which == 0) rx = v;
      else rx7 = v;
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      step(1);
      rd = 1'b0;
   endtask

   task automatic send(input int which, input logic [7:0] b,
                       input int nb, input logic stopv,
                       input logic rel_after);
      int q, d;
      q = cyc;
      d = next_tick(q + 3);
      if (which == 0) begin
         pend_s  = d + (OVS / 2 + OVS * nb + OVS) * DIV;
         pend_b  = b & (8'hFF >> (8 - nb));
         pend_ok = stopv;
         busy_lo = d;
         busy_hi = stopv ? pend_s : BIG;
      end
      drive(which, 1'b0);
      step(BIT);
      for (int i = 0; i < nb; i++) begin
         drive(which, b[i]);
         step(BIT);
      end
      drive(which, stopv);
      step(BIT);
      if (rel_after) begin
         drive(which, 1'b1);
         if (!stopv && which == 0) busy_hi = next_tick(cyc + 3);
      end
   endtask

   initial begin : stim
      int q, lat, s7;
      logic [7:0] b;
      logic sv;
      async_reset = 1'b1;
      rx = 1'b1; rd = 1'b0; rx7 = 1'b1; rd7 = 1'b0;
      model_clear();
      step(3);
      check("rst_data", data, 8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_flags", {overrun, framing_err}, 2'b00);
      async_reset = 1'b0;
      rel = cyc;
      step(2 * BIT);

      // 0x55 with latency window
      q = cyc;
      send(0, 8'h55, 8, 1'b1, 1'b1);
      lat = rise_cyc - q;
      check("latency_window",
            (lat >= (19 * BIT) / 2 && lat <= (19 * BIT) / 2 + DIV + 2), 1);
      check("data_55", data, 8'h55);
      check("valid_55", valid, 1'b1);
      check("busy_55", busy, 1'b0);
      pulse_rd();
      check("valid_after_rd", valid, 1'b0);
      step(BIT);

      // overrun keeps the first character
      send(0, 8'hA3, 8, 1'b1, 1'b1);
      step(BIT / 2);
      send(0, 8'h3C, 8, 1'b1, 1'b1);
      step(BIT / 2);
      check("ovr_data", data, 8'hA3);
      check("ovr_flag", overrun, 1'b1);
      pulse_rd();
      check("ovr_clr_valid", valid, 1'b0);
      check("ovr_clr_flag", overrun, 1'b0);
      step(BIT);

      // short glitch is rejected
      q = cyc;
      busy_lo = next_tick(q + 3);
      busy_hi = busy_lo + (OVS / 2) * DIV;
      rx = 1'b0;
      step(20);
      rx = 1'b1;
      step(2 * BIT);
      check("glitch_valid", valid, 1'b0);
      check("glitch_fe", framing_err, 1'b0);

      // held-low break after bad stop
      fe_rises = 0;
      send(0, 8'h00, 8, 1'b0, 1'b0);
      step(20 * BIT);
      check("brk_fe_once", fe_rises, 1);
      check("brk_valid", valid, 1'b0);
      check("brk_busy", busy, 1'b1);
      rx = 1'b1;
      busy_hi = next_tick(cyc + 3);
      step(BIT);
      check("brk_idle", busy, 1'b0);
      pulse_rd();
      check("brk_fe_clr", framing_err, 1'b0);
      send(0, 8'h81, 8, 1'b1, 1'b1);
      step(BIT);
      check("data_81", data, 8'h81);

      // reset midway through bit 4 of 0xFF
      q = cyc;
      busy_lo = next_tick(q + 3);
      busy_hi = BIG;
      rx = 1'b0;
      step(BIT);
      rx = 1'b1;
      step(4 * BIT + BIT / 2);
      check("pre_rst_busy", busy, 1'b1);
      async_reset = 1'b1;
      model_clear();
      #1;
      check("async_data", data, 8'h00);
      check("async_valid", valid, 1'b0);
      check("async_busy", busy, 1'b0);
      step(3);
      async_reset = 1'b0;
      rel = cyc;
      step(2 * BIT);
      send(0, 8'h12, 8, 1'b1, 1'b1);
      step(BIT);
      check("data_12", data, 8'h12);

      // random traffic against the model
      for (int k = 0; k < 14; k++) begin
         if ($urandom_range(1, 0) == 1) pulse_rd();
         step($urandom_range(2 * BIT, BIT / 2));
         b  = 8'($urandom);
         sv = ($urandom_range(3, 0) != 0);
         send(0, b, 8, sv, 1'b1);
      end
      step(BIT);
      pulse_rd();

      // 7-bit instance: rd coincides with the stop sample
      send(1, 8'h7F, 7, 1'b1, 1'b1);
      step(BIT);
      check("d7_data", data7, 8'h7F);
      check("d7_valid", valid7, 1'b1);
      q  = cyc;
      s7 = next_tick(q + 3) + (OVS / 2 + OVS * 7 + OVS) * DIV;
      fork
         send(1, 8'h2A, 7, 1'b1, 1'b1);
         begin
            while (cyc < s7 - 1) step(1);
            check("d7_pre_valid", valid7, 1'b1);
            check("d7_pre_data", data7, 8'h7F);
            rd7 = 1'b1;
            step(1);
            rd7 = 1'b0;
            check("d7_new_data", data7, 8'h2A);
            check("d7_new_valid", valid7, 1'b1);
            check("d7_no_ovr", overrun7, 1'b0);
         end
      join
      step(BIT);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
